// File: rtl/map_background_restorer.sv
// Walks a rectangle of the saved map-background RAM and streams each stored pixel to the VGA mux.
// Define MAP_RESTORE_TRANSPARENT_EN to suppress writes of pixels equal to TRANSPARENT_COLOUR.
module map_background_restorer #(
   parameter int unsigned SCREEN_W    = 160,
   parameter int unsigned SCREEN_H    = 120,
   parameter int unsigned MEM_LATENCY = 1
`ifdef MAP_RESTORE_TRANSPARENT_EN
   ,
   parameter logic [8:0]  TRANSPARENT_COLOUR = 9'h000
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [7:0]  x0,
   input  logic [6:0]  y0,
   input  logic [7:0]  w,
   input  logic [6:0]  h,
   output logic        busy,
   output logic        done,
   output logic [14:0] mem_address,
   input  logic [8:0]  mem_q,
   output logic [8:0]  colour,
   output logic [14:0] coordinates,
   output logic        VGA_write_enable
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e      state_q, state_d;
   logic [7:0]  x0_q, x0_d, w_q, w_d, col_q, col_d;
   logic [6:0]  y0_q, y0_d, h_q, h_d, row_q, row_d;
   logic [1:0]  drain_q, drain_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic        we_q, we_d;
   logic [8:0]  colour_q, colour_d;
   logic [14:0] coord_q, coord_d;

   logic [8:0]  cx;
   logic [7:0]  cy;
   logic        pix_valid;
   logic [14:0] pix_crd;

   // Read-side delay line, aligned with mem_q
   logic [MEM_LATENCY-1:0] vld_q;
   logic [14:0]            crd_q [MEM_LATENCY];

   // Wide sums so off-screen pixels are clipped rather than wrapped
   assign cx          = {1'b0, x0_q} + {1'b0, col_q};
   assign cy          = {1'b0, y0_q} + {1'b0, row_q};
   assign pix_valid   = (state_q == StRun) && (32'(cx) < SCREEN_W) && (32'(cy) < SCREEN_H);
   assign pix_crd     = {cx[7:0], cy[6:0]};
   assign mem_address = pix_valid ? 15'(32'(cy) * SCREEN_W + 32'(cx)) : 15'd0;

   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      w_d     = w_q;
      h_d     = h_q;
      col_d   = col_q;
      row_d   = row_q;
      drain_d = drain_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               x0_d    = x0;
               y0_d    = y0;
               w_d     = w;
               h_d     = h;
               col_d   = '0;
               row_d   = '0;
               state_d = (w == 8'd0 || h == 7'd0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (col_q == w_q - 8'd1) begin
               col_d = '0;
               if (row_q == h_q - 7'd1) begin
                  state_d = StDrain;
                  drain_d = '0;
               end else begin
                  row_d = row_q + 7'd1;
               end
            end else begin
               col_d = col_q + 8'd1;
            end
         end
         StDrain: begin
            if (drain_q == 2'(MEM_LATENCY)) state_d = StDone;
            else                            drain_d = drain_q + 2'd1;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      busy_d = (state_d == StRun) || (state_d == StDrain);
      done_d = (state_d == StDone);
   end

   always_comb begin
`ifdef MAP_RESTORE_TRANSPARENT_EN
      we_d = vld_q[MEM_LATENCY-1] && (mem_q != TRANSPARENT_COLOUR);
`else
      we_d = vld_q[MEM_LATENCY-1];
`endif
      colour_d = we_d ? mem_q : colour_q;
      coord_d  = we_d ? crd_q[MEM_LATENCY-1] : coord_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         x0_q     <= '0;
         y0_q     <= '0;
         w_q      <= '0;
         h_q      <= '0;
         col_q    <= '0;
         row_q    <= '0;
         drain_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         we_q     <= 1'b0;
         colour_q <= '0;
         coord_q  <= '0;
      end else begin
         state_q  <= state_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         w_q      <= w_d;
         h_q      <= h_d;
         col_q    <= col_d;
         row_q    <= row_d;
         drain_q  <= drain_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         we_q     <= we_d;
         colour_q <= colour_d;
         coord_q  <= coord_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < MEM_LATENCY; i++) crd_q[i] <= '0;
      end else begin
         vld_q[0] <= pix_valid;
         crd_q[0] <= pix_crd;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            crd_q[i] <= crd_q[i-1];
         end
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign VGA_write_enable = we_q;
   assign colour           = colour_q;
   assign coordinates      = coord_q;

endmodule

// File: doc/map_background_restorer.md
Name: map_background_restorer

Overview:
- Reader side of the 19200x9 map-background RAM that the tower path writes.
- On request, walks a rectangle, reads each stored background pixel and streams colour/coordinates with a write enable to the VGA adapter mux.
- Used to erase car and cursor sprites by restoring the saved map underneath them.
- Screen is 160x120. RAM address = y*160 + x.

Parameters:
- SCREEN_W, 160, screen width in pixels; x >= SCREEN_W is clipped.
- SCREEN_H, 120, screen height in pixels; y >= SCREEN_H is clipped.
- MEM_LATENCY, 1, RAM read latency in cycles (legal values 1 or 2).
- TRANSPARENT_COLOUR, 9'h000, key colour, used only under the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- req  in  1  start request; sampled only in IDLE.
- x0  in  8  rectangle left edge.
- y0  in  7  rectangle top edge.
- w  in  8  rectangle width in pixels.
- h  in  7  rectangle height in pixels.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle completion pulse.
- mem_address  out  15  RAM read address.
- mem_q  in  9  RAM read data, valid MEM_LATENCY cycles after its address.
- colour  out  9  pixel colour to VGA.
- coordinates  out  15  {x[7:0], y[6:0]}.
- VGA_write_enable  out  1  pixel write strobe.

Behaviour:
- Reset: asynchronous, active-high. Takes effect immediately, including mid-rectangle.
  - State returns to IDLE. Pipeline is flushed; no further writes.
  - busy, done, VGA_write_enable, colour, coordinates, mem_address are all 0.
- State machine: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - If req=1 at a clock edge, latch x0/y0/w/h and set col=0, row=0.
  - If w=0 or h=0, go to DONE. Otherwise go to RUN.
- RUN: each cycle issues exactly one pixel (cx = x0+col, cy = y0+row).
  - cx is computed in 9 bits and cy in 8 bits, so there is no wrap.
  - Clipped pixel (cx >= SCREEN_W or cy >= SCREEN_H): mem_address = 0 and the pixel is tagged invalid. It still consumes a cycle.
  - Valid pixel: mem_address = cy*SCREEN_W + cx, driven combinationally from the counters in the issue cycle.
  - Scan order: col increments; at col = w-1, col returns to 0 and row increments.
  - After issuing (w-1, h-1), go to DRAIN.
- Pipeline: the valid tag and packed coordinates are delayed MEM_LATENCY stages, aligned with mem_q.
  - Outputs are registered. A pixel issued in cycle t appears on colour, coordinates and VGA_write_enable in cycle t+MEM_LATENCY+1.
  - VGA_write_enable equals the delayed valid tag.
  - colour and coordinates hold their last values when not writing.
- DRAIN: stays MEM_LATENCY+1 cycles until the pipeline is empty, then goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE.
  - A req arriving in DONE is ignored.
  - req held high in the following IDLE starts a new rectangle.
- Ignored inputs: req while busy. Changes to x0/y0/w/h after acceptance.
- Timing (request accepted at edge 0, first issue in cycle 1):
  - Last issue in cycle w*h.
  - Last write in cycle w*h+MEM_LATENCY+1.
  - done in cycle w*h+MEM_LATENCY+2.
  - Zero-size request: done in cycle 1, no writes.
- Throughput: one pixel per cycle, no stalls. The downstream VGA mux must accept every strobe.

Optional Feature:
- Macro: MAP_RESTORE_TRANSPARENT_EN.
- Defined: a valid pixel whose delayed mem_q equals TRANSPARENT_COLOUR produces VGA_write_enable=0, so those screen pixels are left untouched. Timing and done are unchanged.
- Undefined: every unclipped pixel is written, whatever its colour.

Test Plan:
- Basic 2x2 rectangle, MEM_LATENCY=1: RAM preloaded with addr[8:0]; req with x0=10, y0=5, w=2, h=2.
  - Addresses 810, 811, 970, 971 in cycles 1-4.
  - Writes in cycles 3-6 with coordinates {10,5}, {11,5}, {10,6}, {11,6} and colours 810%512 etc.
  - done in cycle 7.
- Clipping: x0=158, y0=119, w=4, h=2.
  - Only (158,119) and (159,119) are written; 8 issue cycles.
  - done in cycle 8+MEM_LATENCY+2.
- Zero size: w=0, h=3 -> no VGA_write_enable; done pulse in cycle 1; busy never asserted.
- Reset mid-run: assert reset during a 16x16 restore at pixel 40.
  - Same cycle: VGA_write_enable=0, busy=0, no done pulse.
  - A new req after deassertion completes normally.
- Request handling:
  - req held high throughout a 3x1 restore: the second request is accepted only in the IDLE after done.
  - x0 changed mid-run has no effect on issued addresses.
- With MAP_RESTORE_TRANSPARENT_EN: a 4x1 row with mem_q = {000, 1FF, 000, 0A0} gives writes only for the 2nd and 4th pixels.
- Without MAP_RESTORE_TRANSPARENT_EN: same row gives all 4 pixels written.
